flag_indicator: RTL and testbench
=================================

# flag_indicator

Registered status-flag generator for the MicroUAZ ALU. It takes the two ALU operands (RY on `A`, RX on `B`), the adder carry-out and the add/subtract select. Each clock it produces Zero, Carry/Borrow and Negative flags for the current operation. The registered flags feed the control unit's conditional-branch logic.

## Interface
- `N`, default 8: operand width in bits, minimum 2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low; clears `Flags`.
- `A`  in  N  operand RY; minuend when subtracting.
- `B`  in  N  operand RX; subtrahend when subtracting.
- `c_out_suma`  in  1  carry-out of the external adder; used only for addition.
- `Suma_o_Resta`  in  1  operation select: 0 = add (A+B), 1 = subtract (A−B).
- `Flags`  out  3  registered flags: bit0 Z (zero), bit1 C (carry/borrow), bit2 N (negative).

## Operation
- Internal result R, N bits wide, computed combinationally:
  - add: R = (A + B) mod 2^N
  - subtract: R = (A − B) mod 2^N, two's complement
- Z = 1 when R == 0.
- C, add: C = c_out_suma, taken as-is with no internal carry check.
- C, subtract: C = 1 when A < B (unsigned borrow); A == B gives C = 0.
- N = R[N-1].
- Flags update every clock cycle; there is no hold or enable, so the flags always reflect the previous cycle's inputs.
- `Suma_o_Resta` is one bit; any wider value driven on it is truncated to its LSB.
- No other state exists; the block has no FSM.

## Timing
- Inputs are sampled on the rising edge of `clk`; `Flags` changes only at that edge or on reset.
- Latency is 1 cycle: flags for inputs applied before edge k are visible after edge k.
- Reset value of `Flags` is 3'b000.
  - Asserting `rst_n` low forces 3'b000 immediately, without waiting for a clock edge, even mid-operation.
  - While `rst_n` is low, the output holds 3'b000 regardless of clock or inputs.
  - On deassertion, the first rising edge with `rst_n` high loads flags from the current inputs.
- Inputs must be stable for setup/hold around the rising edge; there is no input registering beyond the flag flops.
- Boundary cases:
  - R wrapping to 0 on an add overflow sets Z.
  - A == B on subtract sets Z = 1, C = 0, N = 0.
  - Results with MSB set (e.g. 0x80) set N regardless of operation.

## Test plan
- Reset: hold `rst_n` = 0 with arbitrary inputs and a running clock -> Flags = 3'b000. Release `rst_n`, A = 0, B = 0, add, `c_out_suma` = 1 -> after the next edge Flags = 3'b011 (Z, C).
- Subtract equal: A = 4, B = 4, `Suma_o_Resta` = 1 -> Flags = 3'b001 (Z only).
- Subtract with borrow: A = 4, B = 5, `Suma_o_Resta` = 1 -> R = 0xFF, Flags = 3'b110 (N, C).
- Plain add: A = 3, B = 3, `Suma_o_Resta` = 0, `c_out_suma` = 0 -> R = 6, Flags = 3'b000.
- Add edge cases:
  - A = 0x80, B = 0x80, `c_out_suma` = 1 -> Flags = 3'b011.
  - A = 0x7F, B = 0x01, `c_out_suma` = 0 -> Flags = 3'b100.
- Asynchronous reset mid-run: while Flags = 3'b110, drive `rst_n` low between clock edges -> Flags = 3'b000 immediately, held until release. The first edge after release loads flags from the current inputs.

Source files
------------

// File: rtl/flag_indicator.sv
`default_nettype none
// ============================================================================
// flag_indicator: registered Z/C/N status flags for the MicroUAZ ALU
// Rev 1.0
// ============================================================================
module flag_indicator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         c_out_suma,
  input  logic         Suma_o_Resta,
  output logic [2:0]   Flags
);

  logic [N-1:0] w_result;
  logic         w_zero;
  logic         w_carry;
  logic         w_neg;
  logic [2:0]   r_flags;

  // On subtract the carry flag is an unsigned borrow; on add the external
  // adder's carry-out is trusted as-is.
  always_comb begin
    w_result = Suma_o_Resta ? (A - B) : (A + B);
    w_zero   = (w_result == '0);
    w_carry  = Suma_o_Resta ? (A < B) : c_out_suma;
    w_neg    = w_result[N-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else begin
      r_flags <= {w_neg, w_carry, w_zero};
    end
  end

  assign Flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_flag_indicator.sv
`default_nettype none
// ============================================================================
// tb_flag_indicator: scoreboard bench with directed and random ALU operations
// Rev 1.0
// ============================================================================
module tb_flag_indicator;
  localparam int N = 8;
  localparam int MOD = 2 ** N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_out_suma;
  logic         suma_o_resta;
  logic [2:0]   flags;

  int compared = 0;
  int mismatched = 0;

  logic [2:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  flag_indicator #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (a),
    .B           (b),
    .c_out_suma  (c_out_suma),
    .Suma_o_Resta(suma_o_resta),
    .Flags       (flags)
  );

  // Reference: plain integer arithmetic on the operand values
  function automatic logic [2:0] model(input int av, input int bv,
                                       input logic cin, input logic sub);
    int   r;
    logic z, c, n;
    if (sub) begin
      r = av - bv;
      if (r < 0) r = r + MOD;
      c = (av < bv);
    end else begin
      r = (av + bv) % MOD;
      c = cin;
    end
    z = (r == 0);
    n = (r >= MOD / 2);
    return {n, c, z};
  endfunction

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: flags=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic cin, input logic sub, input string nm);
    a = av;
    b = bv;
    c_out_suma = cin;
    suma_o_resta = sub;
    exp_q.push_back(model(int'(av), int'(bv), cin, sub));
    name_q.push_back(nm);
  endtask

  task automatic apply(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic cin, input logic sub, input string nm);
    @(negedge clk);
    drive(av, bv, cin, sub, nm);
  endtask

  task automatic randomize_inputs();
    a = N'($urandom);
    b = N'($urandom);
    c_out_suma = 1'($urandom);
    suma_o_resta = 1'($urandom);
  endtask

  // Monitor: every clock edge retires the one outstanding expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), flags, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    randomize_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      randomize_inputs();
      check("reset_hold", flags, 3'b000);
    end

    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h00, 8'h00, 1'b1, 1'b0, "release_add_zero_carry");
    apply(8'h04, 8'h04, 1'b0, 1'b1, "sub_equal");
    apply(8'h04, 8'h05, 1'b0, 1'b1, "sub_borrow");
    apply(8'h03, 8'h03, 1'b0, 1'b0, "add_plain");
    apply(8'h80, 8'h80, 1'b1, 1'b0, "add_wrap_zero");
    apply(8'h7F, 8'h01, 1'b0, 1'b0, "add_msb_set");
    apply(8'h00, 8'hFF, 1'b1, 1'b1, "sub_zero_minus_max");

    // Asynchronous reset while the flags hold N and C
    apply(8'h04, 8'h05, 1'b0, 1'b1, "sub_borrow_pre_reset");
    @(posedge clk);
    #2;
    check("pre_reset_flags", flags, 3'b110);
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", flags, 3'b000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      randomize_inputs();
      @(posedge clk);
      #1;
      check("async_reset_held", flags, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'hFF, 8'h01, 1'b1, 1'b0, "release_after_async");

    for (int i = 0; i < 300; i++) begin
      apply(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), "random");
    end
    for (int i = 0; i < 100; i++) begin
      logic [N-1:0] v;
      v = N'($urandom);
      apply(v, v, 1'($urandom), 1'b1, "random_sub_equal");
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain_timeout: pending=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
